host_cmd_parser: RTL and testbench
==================================

HOST_CMD_PARSER -- requirements
Module: host_cmd_parser

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 arm_scs  input  1  raw SPI chip select, active-low, asynchronous to clk.
REQ-004 rx_vld  input  1  one-clk pulse from the SPI byte interface; a received byte is ready.
REQ-005 rx_data  input  8  received byte; valid while rx_vld=1.
REQ-006 tx_data  output  8  byte the SPI byte interface shifts out on the next byte (MSB first).
REQ-007 reg_addr  output  8  register-bank address.
REQ-008 reg_wr_en  output  1  one-clk write strobe.
REQ-009 reg_wr_data  output  8  write data; valid with reg_wr_en.
REQ-010 reg_rd_en  output  1  one-clk read strobe.
REQ-011 reg_rd_data  input  8  read data; valid exactly one clk after reg_rd_en.
REQ-012 cmd_err  output  1  one-clk pulse on an illegal opcode.
REQ-013 busy  output  1  high while a frame is active (synchronized chip select low).

Function
REQ-014 Frame protocol is fixed:
- byte0 = opcode: OP_WR=0x02, OP_RD=0x03.
- byte1 = start address.
- byte2 onward = data bytes (write) or dummy bytes (read).
REQ-015 arm_scs shall pass through a 2-flop synchronizer to give scs_s; busy = ~scs_s, aligned with the byte interface's chip-select gating.
REQ-016 The FSM shall have states IDLE, OPCODE, ADDR, WR_DATA, RD_DATA, IGNORE.
REQ-017 IDLE->OPCODE when scs_s falls; any state->IDLE within 1 clk of scs_s rising, regardless of pending events.
REQ-018 OPCODE, rx_vld: OP_WR->ADDR (write), OP_RD->ADDR (read), other value->IGNORE with cmd_err pulsed in that same cycle.
REQ-019 ADDR, rx_vld: latch rx_data into reg_addr, then go to WR_DATA or RD_DATA.
- For a read, assert reg_rd_en on the cycle after the latch.
REQ-020 WR_DATA, each rx_vld: drive reg_wr_data=rx_data and reg_addr=current address, pulse reg_wr_en the next clk, then increment the address.
REQ-021 RD_DATA, each rx_vld: increment the address and pulse reg_rd_en on the next clk (prefetch).
REQ-022 tx_data shall load reg_rd_data on the clk after each reg_rd_en, so tx_data is updated no more than 3 clk after the triggering rx_vld.
REQ-023 tx_data shall be 0x00 in IDLE, OPCODE, ADDR and IGNORE, and shall hold its value between updates.
REQ-024 Address increment is modulo 256; 0xFF wraps to 0x00.
REQ-025 IGNORE discards all bytes until the frame ends; no strobes are issued.
REQ-026 rx_vld while scs_s=1 shall be ignored.
REQ-027 A frame ending mid-byte leaves no side effect, and any in-flight read capture is dropped.
REQ-028 At most one of reg_wr_en and reg_rd_en is high in any cycle.
REQ-029 System constraint: SCK period is at least 8 clk periods, so tx_data is stable before the next byte's first SCK rising edge.

Reset
REQ-030 While rst_n=0, the following shall hold:
- FSM in IDLE.
- tx_data, reg_addr and reg_wr_data = 0x00.
- reg_wr_en, reg_rd_en and cmd_err = 0.
- Synchronizer flops = 1, so busy = 0.
REQ-031 Reset asserted mid-frame aborts the frame. After release the block waits for the next falling edge of scs_s and does not resume the aborted frame.

Structure
REQ-032 A shared package host_reg_pkg shall hold OP_WR, OP_RD, the FSM state encoding and TX_IDLE_BYTE=0x00.
REQ-033 The chip-select synchronizer shall be the sub-module sync_2ff (reset value parameterized, here 1). All other logic lives in host_cmd_parser.

Verification
REQ-034 Write frame 0x02,0x10,0xAA,0xBB -> reg_wr_en twice: (0x10,0xAA) then (0x11,0xBB); no reg_rd_en.
REQ-035 Read frame 0x03,0xFE + 3 dummy bytes, bank returning addr^0x55 -> reg_rd_en at 0xFE,0xFF,0x00,0x01 (wrap); tx_data sequence 0xAB,0xAA,0x55,0x54; tx_data stable before each next byte's first SCK edge.
REQ-036 Opcode 0x7F followed by 2 bytes -> cmd_err pulses once; no strobes; tx_data stays 0x00; next frame with opcode 0x02 works normally.
REQ-037 Chip select deasserted after the opcode only, then a new write frame 0x02,0x20,0x01 -> single write (0x20,0x01); busy low between frames.
REQ-038 rst_n pulsed low during a read's data phase -> all outputs take their reset values; no strobes until the next frame; the next frame decodes correctly.
REQ-039 rx_vld pulses with arm_scs high -> no state change, no strobes.

Source files
------------

// File: rtl/host_reg_pkg.sv
// Shared definitions for the host command parser: opcodes, FSM state encoding
// and the byte shifted out while no read data is being returned.
package host_reg_pkg;

    localparam logic [7:0] OP_WR        = 8'h02;
    localparam logic [7:0] OP_RD        = 8'h03;
    localparam logic [7:0] TX_IDLE_BYTE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPCODE  = 3'd1,
        ST_ADDR    = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_IGNORE  = 3'd5
    } state_t;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_WR) || (op == OP_RD);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; the reset value is
// chosen by the instantiating block.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/host_cmd_parser.sv
// SPI host command parser: decodes opcode/address/data frames from the byte
// interface into register-bank write and prefetching read strobes.
module host_cmd_parser
    import host_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm_scs,
    input  logic       rx_vld,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       cmd_err,
    output logic       busy
);

    logic   scs_s;
    logic   scs_d_r;
    state_t state_r;
    logic   is_wr_r;
    logic   inc_pend_r;
    logic   cap_pend_r;

    sync_2ff #(.RST_VAL(1'b1)) u_scs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (arm_scs),
        .q     (scs_s)
    );

    assign busy = ~scs_s;

    // Frame FSM with registered strobes, address counter and tx capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scs_d_r     <= 1'b1;
            state_r     <= ST_IDLE;
            is_wr_r     <= 1'b0;
            inc_pend_r  <= 1'b0;
            cap_pend_r  <= 1'b0;
            tx_data     <= TX_IDLE_BYTE;
            reg_addr    <= 8'h00;
            reg_wr_data <= 8'h00;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            scs_d_r    <= scs_s;
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            cmd_err    <= 1'b0;
            inc_pend_r <= 1'b0;
            cap_pend_r <= reg_rd_en;
            if (scs_s) begin
                // Frame over: pending increments and read captures are dropped.
                state_r    <= ST_IDLE;
                cap_pend_r <= 1'b0;
                tx_data    <= TX_IDLE_BYTE;
            end else begin
                if (inc_pend_r) begin
                    reg_addr <= reg_addr + 8'd1;
                end else begin
                    reg_addr <= reg_addr;
                end
                case (state_r)
                    ST_IDLE: begin
                        tx_data <= TX_IDLE_BYTE;
                        if (scs_d_r) begin
                            state_r <= ST_OPCODE;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_OPCODE: begin
                        tx_data <= TX_IDLE_BYTE;
                        if (rx_vld) begin
                            if (is_known_op(rx_data)) begin
                                is_wr_r <= (rx_data == OP_WR);
                                state_r <= ST_ADDR;
                            end else begin
                                cmd_err <= 1'b1;
                                state_r <= ST_IGNORE;
                            end
                        end else begin
                            state_r <= ST_OPCODE;
                        end
                    end
                    ST_ADDR: begin
                        tx_data <= TX_IDLE_BYTE;
                        if (rx_vld) begin
                            reg_addr <= rx_data;
                            if (is_wr_r) begin
                                state_r <= ST_WR_DATA;
                            end else begin
                                reg_rd_en <= 1'b1;
                                state_r   <= ST_RD_DATA;
                            end
                        end else begin
                            state_r <= ST_ADDR;
                        end
                    end
                    ST_WR_DATA: begin
                        // Address advances one clk after the strobe it qualified.
                        if (rx_vld) begin
                            reg_wr_data <= rx_data;
                            reg_wr_en   <= 1'b1;
                            inc_pend_r  <= 1'b1;
                        end else begin
                            reg_wr_data <= reg_wr_data;
                        end
                    end
                    ST_RD_DATA: begin
                        if (cap_pend_r) begin
                            tx_data <= reg_rd_data;
                        end else begin
                            tx_data <= tx_data;
                        end
                        if (rx_vld) begin
                            reg_addr  <= reg_addr + 8'd1;
                            reg_rd_en <= 1'b1;
                        end else begin
                            reg_rd_en <= 1'b0;
                        end
                    end
                    ST_IGNORE: begin
                        tx_data <= TX_IDLE_BYTE;
                    end
                    default: begin
                        tx_data <= TX_IDLE_BYTE;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_host_cmd_parser.sv
// Self-checking bench for host_cmd_parser: directed frames plus random frames
// scored against a frame-level model of the expected strobes and tx bytes.
module tb_host_cmd_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm_scs = 1'b1;
    logic       rx_vld = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] reg_rd_data;
    logic [7:0] tx_data;
    logic [7:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic       cmd_err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    int          err_cnt = 0;
    int          ovl_cnt = 0;

    logic [7:0]  fbuf[8];
    int          flen;

    host_cmd_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm_scs     (arm_scs),
        .rx_vld      (rx_vld),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .cmd_err     (cmd_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Register bank: returns addr^0x55 one clk after a read strobe, junk otherwise.
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= reg_addr ^ 8'h55;
        else           reg_rd_data <= 8'($urandom);
    end

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reg_wr_en) wr_q.push_back({reg_addr, reg_wr_data});
        if (reg_rd_en) rd_q.push_back(reg_addr);
        if (cmd_err) err_cnt++;
        if (reg_wr_en && reg_rd_en) ovl_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_vld  = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_vld  = 1'b0;
        rx_data = 8'($urandom);
    endtask

    // Drives fbuf[0:flen-1] as one frame and scores it against the frame model.
    task automatic run_frame(input string tag);
        int          wb = wr_q.size();
        int          rb = rd_q.size();
        int          eb = err_cnt;
        int          ob = ovl_cnt;
        logic [7:0]  op = fbuf[0];
        logic [7:0]  base = fbuf[1];
        logic [7:0]  a;
        bit          is_wr = (flen >= 1) && (op == 8'h02);
        bit          is_rd = (flen >= 1) && (op == 8'h03);
        bit          bad = (flen >= 1) && !is_wr && !is_rd;
        int          exp_wr = (is_wr && flen >= 2) ? flen - 2 : 0;
        int          exp_rd = (is_rd && flen >= 2) ? flen - 1 : 0;
        int          n;
        logic [7:0]  exp_tx;

        arm_scs = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, " busy_on"}, 32'(busy), 32'd1);
        for (int i = 0; i < flen; i++) begin
            repeat ($urandom_range(10, 4)) @(negedge clk);
            a = base + 8'(i - 2);
            exp_tx = (is_rd && i >= 2) ? (a ^ 8'h55) : 8'h00;
            chk($sformatf("%s tx_b%0d", tag, i), 32'(tx_data), 32'(exp_tx));
            send_byte(fbuf[i]);
        end
        repeat (5) @(negedge clk);
        a = base + 8'(flen - 2);
        exp_tx = (is_rd && flen >= 2) ? (a ^ 8'h55) : 8'h00;
        chk({tag, " tx_last"}, 32'(tx_data), 32'(exp_tx));
        arm_scs = 1'b1;
        repeat (4) @(negedge clk);
        chk({tag, " busy_off"}, 32'(busy), 32'd0);
        chk({tag, " tx_idle"}, 32'(tx_data), 32'd0);

        n = wr_q.size() - wb;
        chk({tag, " n_wr"}, 32'(n), 32'(exp_wr));
        for (int k = 0; k < n && k < exp_wr; k++) begin
            a = base + 8'(k);
            chk($sformatf("%s wr%0d", tag, k), 32'(wr_q[wb + k]), 32'({a, fbuf[2 + k]}));
        end
        n = rd_q.size() - rb;
        chk({tag, " n_rd"}, 32'(n), 32'(exp_rd));
        for (int k = 0; k < n && k < exp_rd; k++) begin
            a = base + 8'(k);
            chk($sformatf("%s rd%0d", tag, k), 32'(rd_q[rb + k]), 32'(a));
        end
        chk({tag, " cmd_err"}, 32'(err_cnt - eb), bad ? 32'd1 : 32'd0);
        chk({tag, " overlap"}, 32'(ovl_cnt - ob), 32'd0);
    endtask

    initial begin
        int wb;
        int rb;
        int eb;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst tx", 32'(tx_data), 32'd0);
        chk("rst addr", 32'(reg_addr), 32'd0);
        chk("rst wr_data", 32'(reg_wr_data), 32'd0);
        chk("rst strobes", 32'({reg_wr_en, reg_rd_en, cmd_err}), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // rx_vld with chip select high is ignored.
        for (int i = 0; i < 3; i++) send_byte(8'h02 + 8'(i));
        repeat (4) @(negedge clk);
        chk("idle_rx n_wr", 32'(wr_q.size()), 32'd0);
        chk("idle_rx n_rd", 32'(rd_q.size()), 32'd0);
        chk("idle_rx err", 32'(err_cnt), 32'd0);
        chk("idle_rx busy", 32'(busy), 32'd0);

        fbuf[0] = 8'h02; fbuf[1] = 8'h10; fbuf[2] = 8'hAA; fbuf[3] = 8'hBB; flen = 4;
        run_frame("wr_frame");
        fbuf[0] = 8'h03; fbuf[1] = 8'hFE; fbuf[2] = 8'h00; fbuf[3] = 8'h00; fbuf[4] = 8'h00; flen = 5;
        run_frame("rd_wrap");
        fbuf[0] = 8'h7F; fbuf[1] = 8'h12; fbuf[2] = 8'h34; flen = 3;
        run_frame("bad_op");
        fbuf[0] = 8'h02; fbuf[1] = 8'h30; fbuf[2] = 8'h5A; flen = 3;
        run_frame("after_bad");
        fbuf[0] = 8'h02; flen = 1;
        run_frame("op_only");
        fbuf[0] = 8'h02; fbuf[1] = 8'h20; fbuf[2] = 8'h01; flen = 3;
        run_frame("after_abort");

        // Reset during a read data phase.
        arm_scs = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h03);
        repeat (5) @(negedge clk);
        send_byte(8'h40);
        repeat (5) @(negedge clk);
        send_byte(8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst tx", 32'(tx_data), 32'd0);
        chk("midrst addr", 32'(reg_addr), 32'd0);
        chk("midrst wr_data", 32'(reg_wr_data), 32'd0);
        chk("midrst strobes", 32'({reg_wr_en, reg_rd_en, cmd_err}), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        wb = wr_q.size(); rb = rd_q.size(); eb = err_cnt;
        arm_scs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("postrst strobes", 32'((wr_q.size() - wb) + (rd_q.size() - rb) + (err_cnt - eb)), 32'd0);
        fbuf[0] = 8'h03; fbuf[1] = 8'h41; fbuf[2] = 8'h00; flen = 3;
        run_frame("postrst_rd");

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            case ($urandom_range(3, 0))
                0:       fbuf[0] = 8'h02;
                1:       fbuf[0] = 8'h03;
                2:       fbuf[0] = 8'($urandom);
                default: fbuf[0] = 8'h03;
            endcase
            fbuf[1] = ($urandom_range(1, 0) == 0) ? 8'($urandom) : 8'hFC + 8'($urandom_range(3, 0));
            for (int i = 2; i < 8; i++) fbuf[i] = 8'($urandom);
            flen = $urandom_range(6, 0);
            run_frame($sformatf("rnd%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
